// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared FSM states and code constants for the encoder frame path
package conv_enc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_ENC, S_TAIL, S_FLUSH} state_t;
  localparam int TAIL_LEN = 2;
  localparam int N_OUT = 2;
endpackage

// File: rtl/conv_enc_frame_ctrl_if.sv
// conv_enc_frame_ctrl_if: source/encoder/sink signals around the frame sequencer
interface conv_enc_frame_ctrl_if
  import conv_enc_pkg::*;
#(
  parameter int LEN_W = 7
);
  logic start, abort, in_bit, in_valid, in_ready;
  logic [LEN_W-1:0] frame_len;
  logic enc_x, enc_rst_n;
  logic [N_OUT-1:0] enc_y, sym_out;
  logic sym_valid, sym_last, busy, done, err;
  modport master (
    output start, frame_len, abort, in_bit, in_valid, enc_y,
    input in_ready, enc_x, enc_rst_n, sym_out, sym_valid, sym_last, busy, done, err
  );
  modport slave (
    input start, frame_len, abort, in_bit, in_valid, enc_y,
    output in_ready, enc_x, enc_rst_n, sym_out, sym_valid, sym_last, busy, done, err
  );
endinterface

// File: rtl/conv_enc_frame_buf.sv
// conv_enc_frame_buf: MAX_LEN x 1 frame store, combinational read, bulk clear
module conv_enc_frame_buf #(
  parameter int MAX_LEN = 64,
  parameter int AW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);
  logic [MAX_LEN-1:0] mem;
  // bit storage; clear wipes the whole frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem <= '0;
    else if (clr) mem <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// conv_enc_frame_ctrl: buffers a frame, clears the encoder, streams it with a zero tail
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int TAIL_LEN = conv_enc_pkg::TAIL_LEN,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input logic clk,
  input logic reset,
  conv_enc_frame_ctrl_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TAIL_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN - 1);
  state_t state, next;
  logic [LEN_W-1:0] len_q, wr_cnt, rd_cnt;
  logic [TW-1:0] tail_cnt;
  logic legal, wr_fire, rd_data;
  assign legal = bus.frame_len != '0 && bus.frame_len <= MAX_L;
  assign wr_fire = state == S_LOAD && bus.in_valid;
  conv_enc_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk),
    .reset(reset),
    .clr(bus.abort),
    .wr_en(wr_fire && !bus.abort),
    .wr_addr(wr_cnt[AW-1:0]),
    .wr_data(bus.in_bit),
    .rd_addr(rd_cnt[AW-1:0]),
    .rd_data(rd_data)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next;
  // next-state: abort overrides every transition
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = bus.start && legal ? S_LOAD : S_IDLE;
      S_LOAD:  next = wr_fire && wr_cnt == len_q - LEN_W'(1) ? S_CLEAR : S_LOAD;
      S_CLEAR: next = S_ENC;
      S_ENC:   next = rd_cnt == len_q - LEN_W'(1) ? S_TAIL : S_ENC;
      S_TAIL:  next = tail_cnt == TAIL_LAST ? S_FLUSH : S_TAIL;
      S_FLUSH: next = S_IDLE;
      default: next = S_IDLE;
    endcase
    if (bus.abort) next = S_IDLE;
  end
  // combinational outputs; enc_x is forced to 0 outside ENC so tail and idle feed zeros
  always_comb begin
    bus.in_ready = state == S_LOAD;
    bus.busy = state != S_IDLE;
    bus.enc_x = state == S_ENC && rd_data;
    bus.sym_out = bus.sym_valid ? bus.enc_y : '0;
  end
  // counters and registered outputs; enc_rst_n drops for the CLEAR cycle so the encoder clears on its closing edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {len_q, wr_cnt, rd_cnt, tail_cnt} <= '0;
      {bus.enc_rst_n, bus.sym_valid, bus.sym_last, bus.done, bus.err} <= '0;
    end else if (bus.abort) begin
      {len_q, wr_cnt, rd_cnt, tail_cnt} <= '0;
      {bus.enc_rst_n, bus.sym_valid, bus.sym_last, bus.done, bus.err} <= '0;
    end else begin
      len_q <= state == S_IDLE && bus.start && legal ? bus.frame_len : len_q;
      wr_cnt <= state == S_LOAD ? wr_cnt + LEN_W'(wr_fire) : '0;
      rd_cnt <= state == S_ENC ? rd_cnt + LEN_W'(1) : '0;
      tail_cnt <= state == S_TAIL ? tail_cnt + TW'(1) : '0;
      bus.enc_rst_n <= next != S_CLEAR;
      bus.sym_valid <= state == S_ENC || state == S_TAIL;
      bus.sym_last <= state == S_TAIL && tail_cnt == TAIL_LAST;
      bus.done <= state == S_FLUSH;
      bus.err <= state == S_IDLE && bus.start && !legal;
    end
endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// tb_conv_enc_frame_ctrl: directed checks of the frame sequencer driving a (7,5) K=3 encoder
module tb_conv_enc_frame_ctrl;
  localparam int MAX_LEN = 64;
  localparam int LEN_W = 7;
  logic clk = 0;
  logic reset = 0;
  int errors = 0;
  int checks = 0;
  logic tx_bits[MAX_LEN];
  logic [1:0] exp_sym[MAX_LEN + 2];
  logic [1:0] enc_s;
  logic [1:0] hand6[8] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11};
  always #5 clk = ~clk;
  conv_enc_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();
  conv_enc_frame_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  // encoder under the sequencer: registered y, synchronous active-low clear, state[0] newest bit
  always @(posedge clk)
    if (!bus.enc_rst_n) begin
      enc_s <= 2'b00;
      bus.enc_y <= 2'b00;
    end else begin
      bus.enc_y <= {bus.enc_x ^ enc_s[0] ^ enc_s[1], bus.enc_x ^ enc_s[1]};
      enc_s <= {enc_s[0], bus.enc_x};
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic gold(input int len);
    logic [1:0] s = 2'b00;
    logic x;
    for (int i = 0; i < len + 2; i++) begin
      x = i < len ? tx_bits[i] : 1'b0;
      exp_sym[i] = {x ^ s[0] ^ s[1], x ^ s[1]};
      s = {s[0], x};
    end
  endtask
  task automatic start_frame(input int len);
    bus.start = 1;
    bus.frame_len = LEN_W'(len);
    @(negedge clk);
    bus.start = 0;
    check("load_ready", bus.in_ready, 1);
    check("load_busy", bus.busy, 1);
  endtask
  task automatic feed(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1;
      bus.in_bit = tx_bits[i];
      @(negedge clk);
      bus.in_valid = 0;
      if (i < len - 1) repeat (gap) @(negedge clk);
    end
  endtask
  task automatic collect(input string tag, input int len);
    int n = 0;
    int gaps = 0;
    int extra = 0;
    logic prev_last = 0;
    logic got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.sym_valid) begin
        check({tag, "_sym"}, bus.sym_out, n < len + 2 ? exp_sym[n] : 2'bxx);
        check({tag, "_last"}, bus.sym_last, n == len + 1);
        n++;
      end else if (n > 0 && n < len + 2) gaps++;
      if (bus.done) begin
        got = 1;
        check({tag, "_done_after_last"}, prev_last, 1);
        check({tag, "_count"}, n, len + 2);
        check({tag, "_enc_state"}, enc_s, 0);
        check({tag, "_idle"}, bus.busy, 0);
      end
      prev_last = bus.sym_last;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_no_gaps"}, gaps, 0);
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.sym_valid) extra++;
    end
    check({tag, "_done_once"}, extra, 0);
  endtask
  initial begin
    int quiet;
    bus.start = 0;
    bus.frame_len = '0;
    bus.abort = 0;
    bus.in_bit = 0;
    bus.in_valid = 0;
    repeat (3) @(negedge clk);
    check("rst_enc_rst_n", bus.enc_rst_n, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sym_valid", bus.sym_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_sym_out", bus.sym_out, 0);
    reset = 1;
    @(negedge clk);
    check("rel_enc_rst_n", bus.enc_rst_n, 1);
    check("rel_busy", bus.busy, 0);
    tx_bits[0:5] = '{1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) exp_sym[i] = hand6[i];
    start_frame(6);
    feed(6, 0);
    check("clear_in_ready", bus.in_ready, 0);
    check("clear_enc_rst_n", bus.enc_rst_n, 0);
    collect("f6", 6);
    tx_bits[0] = 1;
    gold(1);
    start_frame(1);
    feed(1, 0);
    collect("f1", 1);
    for (int i = 0; i < MAX_LEN; i++) tx_bits[i] = 1'($urandom_range(0, 1));
    gold(MAX_LEN);
    start_frame(MAX_LEN);
    feed(MAX_LEN, 0);
    collect("f64", MAX_LEN);
    bus.start = 1;
    bus.frame_len = LEN_W'(0);
    @(negedge clk);
    bus.start = 0;
    check("len0_err", bus.err, 1);
    check("len0_busy", bus.busy, 0);
    check("len0_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("len0_err_pulse", bus.err, 0);
    bus.start = 1;
    bus.frame_len = LEN_W'(65);
    @(negedge clk);
    bus.start = 0;
    check("len65_err", bus.err, 1);
    check("len65_busy", bus.busy, 0);
    check("len65_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("len65_err_pulse", bus.err, 0);
    tx_bits[0:3] = '{1, 0, 1, 1};
    gold(4);
    start_frame(4);
    feed(4, 0);
    collect("f4", 4);
    start_frame(4);
    feed(4, 2);
    collect("f4gap", 4);
    bus.start = 1;
    bus.frame_len = LEN_W'(5);
    bus.abort = 1;
    @(negedge clk);
    bus.start = 0;
    bus.abort = 0;
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_err", bus.err, 0);
    tx_bits[0:5] = '{1, 0, 1, 1, 0, 1};
    start_frame(6);
    feed(6, 0);
    repeat (3) @(negedge clk);
    check("abort_pre_valid", bus.sym_valid, 1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    check("abort_sym_valid", bus.sym_valid, 0);
    check("abort_enc_rst_n", bus.enc_rst_n, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("abort_enc_rst_n_rel", bus.enc_rst_n, 1);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.sym_valid || bus.sym_last) quiet++;
    end
    check("abort_quiet", quiet, 0);
    tx_bits[0:5] = '{0, 1, 1, 0, 1, 0};
    gold(6);
    start_frame(6);
    feed(6, 0);
    collect("post_abort", 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
